// File: rtl/rgb2hsv_seq.sv
// Handshaked RGB-to-HSV converter: one pixel in flight, hue and saturation
// computed by a single shared restoring divider for exact floor results.
module rgb2hsv_seq #(
  parameter int DW       = 8,
  parameter int TAG_W    = 2,
  parameter int SAT_MODE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    red,
  input  logic [DW-1:0]    green,
  input  logic [DW-1:0]    blue,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [8:0]       hue,
  output logic [DW-1:0]    saturation,
  output logic [DW-1:0]    value,
  output logic [TAG_W-1:0] out_tag
);

  localparam int QW   = DW + 7;       // quotient/dividend bits, one per divide cycle
  localparam int PW   = 2 * DW + 7;   // full saturation numerator width
  localparam int CW   = $clog2(QW);
  localparam int K    = (SAT_MODE != 0) ? ((1 << DW) - 1) : 100;

  typedef enum logic [2:0] {IDLE, CMP, DIV_H, DIV_S, FIN, HOLD} state_e;
  typedef enum logic [1:0] {SEC_R, SEC_G, SEC_B} sector_e;

  state_e           state_q;
  sector_e          sec_q;
  logic [DW-1:0]    r_q, g_q, b_q;
  logic [TAG_W-1:0] tag_q;
  logic [DW-1:0]    max_q, diff_q;
  logic             neg_q;
  logic [6:0]       qh_q;
  logic [DW-1:0]    rem_q, dvs_q;
  logic [QW-1:0]    dvd_q;
  logic [CW-1:0]    cnt_q;
  logic             in_ready_q, out_valid_q;
  logic [8:0]       hue_q;
  logic [DW-1:0]    sat_q, val_q;
  logic [TAG_W-1:0] otag_q;

  // Combinational helpers feeding the FSM
  sector_e       sec_d;
  logic [DW-1:0] mx, mn, n_abs;
  logic          n_neg;
  logic [QW-1:0] h_num;
  logic [PW-1:0] s_num;
  logic [DW:0]   trial;
  logic          take;
  logic [DW-1:0] rem_d;
  logic [QW-1:0] dvd_d;
  logic [8:0]    qh9, hue_d;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    mx    = r_q;
    mn    = r_q;
    sec_d = SEC_B;
    n_neg = 1'b0;
    n_abs = '0;
    hue_d = '0;
    if (g_q > mx) mx = g_q;
    if (b_q > mx) mx = b_q;
    if (g_q < mn) mn = g_q;
    if (b_q < mn) mn = b_q;

    // Ties resolve toward R, then G
    if (r_q >= g_q && r_q >= b_q) begin
      sec_d = SEC_R;
      n_neg = g_q < b_q;
      n_abs = n_neg ? (b_q - g_q) : (g_q - b_q);
    end else if (g_q >= b_q) begin
      sec_d = SEC_G;
      n_neg = b_q < r_q;
      n_abs = n_neg ? (r_q - b_q) : (b_q - r_q);
    end else begin
      sec_d = SEC_B;
      n_neg = r_q < g_q;
      n_abs = n_neg ? (g_q - r_q) : (r_q - g_q);
    end

    h_num = QW'(n_abs) * QW'(60);
    s_num = PW'(K) * PW'(diff_q);

    // One restoring step: shift in the next dividend bit, subtract if it fits
    trial = {rem_q, dvd_q[QW-1]};
    take  = trial >= {1'b0, dvs_q};
    rem_d = take ? DW'(trial - {1'b0, dvs_q}) : trial[DW-1:0];
    dvd_d = {dvd_q[QW-2:0], take};

    qh9 = {2'b00, qh_q};
    case (sec_q)
      SEC_R:   hue_d = neg_q ? ((qh_q == '0) ? 9'd0 : 9'd360 - qh9) : qh9;
      SEC_G:   hue_d = neg_q ? 9'd120 - qh9 : 9'd120 + qh9;
      SEC_B:   hue_d = neg_q ? 9'd240 - qh9 : 9'd240 + qh9;
      default: hue_d = '0;
    endcase
  end

  // NOTE: all state below is assigned with <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sec_q       <= SEC_R;
      r_q         <= '0;
      g_q         <= '0;
      b_q         <= '0;
      tag_q       <= '0;
      max_q       <= '0;
      diff_q      <= '0;
      neg_q       <= 1'b0;
      qh_q        <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      dvd_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      hue_q       <= '0;
      sat_q       <= '0;
      val_q       <= '0;
      otag_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            r_q        <= red;
            g_q        <= green;
            b_q        <= blue;
            tag_q      <= in_tag;
            in_ready_q <= 1'b0;
            state_q    <= CMP;
          end
        end
        CMP: begin
          max_q   <= mx;
          diff_q  <= mx - mn;
          sec_q   <= sec_d;
          neg_q   <= n_neg;
          rem_q   <= '0;
          dvd_q   <= h_num;
          dvs_q   <= mx - mn;
          cnt_q   <= '0;
          state_q <= DIV_H;
        end
        DIV_H: begin
          rem_q <= rem_d;
          dvd_q <= dvd_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(QW - 1)) begin
            // Preloading the high numerator bits keeps DW+7 steps exact: quotient < 2^DW
            qh_q    <= dvd_d[6:0];
            rem_q   <= s_num[PW-1:QW];
            dvd_q   <= s_num[QW-1:0];
            dvs_q   <= max_q;
            cnt_q   <= '0;
            state_q <= DIV_S;
          end
        end
        DIV_S: begin
          rem_q <= rem_d;
          dvd_q <= dvd_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(QW - 1)) begin
            cnt_q   <= '0;
            state_q <= FIN;
          end
        end
        FIN: begin
          hue_q       <= (diff_q == '0) ? 9'd0 : hue_d;
          sat_q       <= (diff_q == '0) ? '0 : dvd_q[DW-1:0];
          val_q       <= max_q;
          otag_q      <= tag_q;
          out_valid_q <= 1'b1;
          state_q     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign hue        = hue_q;
  assign saturation = sat_q;
  assign value      = val_q;
  assign out_tag    = otag_q;

endmodule
